// File: rtl/rom_arbiter.sv
// Two-port arbiter in front of a single registered-read ROM: grants one read at a time,
// alternates on conflict, and answers out-of-range addresses with an error response.
module rom_arbiter #(
   parameter logic [31:0] ADDR_MAX = 32'd1020
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0,
   input  logic        req1,
   input  logic [31:0] addr0,
   input  logic [31:0] addr1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        valid0,
   output logic        valid1,
   output logic [31:0] rdata0,
   output logic [31:0] rdata1,
   output logic        err0,
   output logic        err1,
   output logic [31:0] rom_addr,
   output logic        rom_enable,
   input  logic [31:0] rom_data,
   output logic        busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_ERR   = 2'd3
   } state_t;

   state_t      r_state;
   logic        r_owner;
   logic        r_last;
   logic [1:0]  r_gnt;
   logic [1:0]  r_valid;
   logic [1:0]  r_err;
   logic [31:0] r_rdata [2];
   logic [31:0] r_rom_addr;
   logic        r_rom_en;

   logic        w_any;
   logic        w_win;
   logic [31:0] w_addr;
   logic        w_legal;

   // On conflict the port that did not win last time goes next.
   assign w_any   = req0 | req1;
   assign w_win   = (req0 & req1) ? ~r_last : req1;
   assign w_addr  = w_win ? addr1 : addr0;
   assign w_legal = (w_addr <= ADDR_MAX);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_owner    <= 1'b0;
         r_last     <= 1'b1;
         r_gnt      <= 2'b00;
         r_valid    <= 2'b00;
         r_err      <= 2'b00;
         r_rdata[0] <= 32'd0;
         r_rdata[1] <= 32'd0;
         r_rom_addr <= 32'd0;
         r_rom_en   <= 1'b0;
      end else begin
         r_gnt   <= 2'b00;
         r_valid <= 2'b00;
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_gnt[w_win] <= 1'b1;
                  r_last       <= w_win;
                  r_owner      <= w_win;
                  if (w_legal) begin
                     r_rom_addr <= w_addr;
                     r_rom_en   <= 1'b1;
                     r_state    <= S_ISSUE;
                  end else begin
                     r_state <= S_ERR;
                  end
               end
            end
            S_ISSUE: begin
               r_rom_en <= 1'b0;
               r_state  <= S_WAIT;
            end
            S_WAIT: begin
               r_rdata[r_owner] <= rom_data;
               r_err[r_owner]   <= 1'b0;
               r_valid[r_owner] <= 1'b1;
               r_state          <= S_IDLE;
            end
            S_ERR: begin
               r_rdata[r_owner] <= 32'd0;
               r_err[r_owner]   <= 1'b1;
               r_valid[r_owner] <= 1'b1;
               r_state          <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign gnt0       = r_gnt[0];
   assign gnt1       = r_gnt[1];
   assign valid0     = r_valid[0];
   assign valid1     = r_valid[1];
   assign err0       = r_err[0];
   assign err1       = r_err[1];
   assign rdata0     = r_rdata[0];
   assign rdata1     = r_rdata[1];
   assign rom_addr   = r_rom_addr;
   assign rom_enable = r_rom_en;
   assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: stimulus pushes expected grants/responses into queues,
// a negedge monitor pops and compares whenever the DUT pulses gnt or valid.
module tb_rom_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0, req1;
   logic [31:0] addr0, addr1;
   logic        gnt0, gnt1, valid0, valid1, err0, err1;
   logic [31:0] rdata0, rdata1, rom_addr;
   logic        rom_enable, busy;
   logic [31:0] rom_data = 32'd0;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   typedef struct {
      int          port;
      logic [31:0] data;
      logic        err;
   } rsp_t;

   rsp_t rsp_q [$];
   int   gnt_q [$];
   rsp_t mon_rsp;
   int   mon_port;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   rom_arbiter #(.ADDR_MAX(32'd1020)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
      .gnt0(gnt0), .gnt1(gnt1), .valid0(valid0), .valid1(valid1),
      .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
      .rom_addr(rom_addr), .rom_enable(rom_enable), .rom_data(rom_data),
      .busy(busy)
   );

   // ROM contents: byte i holds i for i < 16, zero elsewhere; little-endian words.
   function automatic logic [7:0] rom_byte(input logic [31:0] a);
      return (a < 32'd16) ? a[7:0] : 8'h00;
   endfunction

   always @(posedge clk)
      if (rom_enable)
         rom_data <= {rom_byte(rom_addr + 32'd3), rom_byte(rom_addr + 32'd2),
                      rom_byte(rom_addr + 32'd1), rom_byte(rom_addr)};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic flag(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s: got event expected none", name);
   endtask

   // Monitor: one-hot checks plus in-order scoreboard for grants and responses.
   always @(negedge clk) begin
      if (gnt0 && gnt1) flag("gnt_both");
      if (valid0 && valid1) flag("valid_both");
      if (gnt0 || gnt1) begin
         if (gnt_q.size() == 0) flag("gnt_unexpected");
         else begin
            mon_port = gnt_q.pop_front();
            check("gnt_port", gnt1 ? 32'd1 : 32'd0, 32'(mon_port));
         end
      end
      if (valid0 || valid1) begin
         if (rsp_q.size() == 0) flag("valid_unexpected");
         else begin
            mon_rsp = rsp_q.pop_front();
            $display("txn t=%0d port=%0d rdata=%h err=%b", cyc, valid1 ? 1 : 0,
                     valid1 ? rdata1 : rdata0, valid1 ? err1 : err0);
            check("valid_port", valid1 ? 32'd1 : 32'd0, 32'(mon_rsp.port));
            check("rdata", valid1 ? rdata1 : rdata0, mon_rsp.data);
            check("err", {31'd0, valid1 ? err1 : err0}, {31'd0, mon_rsp.err});
         end
      end
   end

   task automatic reset_dut();
      reset = 1'b1;
      req0  = 1'b0;
      req1  = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic wait_drain();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (rsp_q.size() == 0 && gnt_q.size() == 0) begin
            done = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("drain", {31'd0, done}, 32'd1);
   endtask

   // Single read on one port; checks grant, ROM enable behaviour and response latency.
   task automatic do_read(input int port, input logic [31:0] a,
                          input logic [31:0] exp_d, input logic exp_e);
      bit   got;
      rsp_t r;
      r = '{port, exp_d, exp_e};
      gnt_q.push_back(port);
      rsp_q.push_back(r);
      @(negedge clk);
      if (port == 0) begin req0 = 1'b1; addr0 = a; end
      else           begin req1 = 1'b1; addr1 = a; end
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if ((port == 0 && gnt0) || (port == 1 && gnt1)) begin
            got = 1'b1;
            break;
         end
      end
      if (port == 0) req0 = 1'b0;
      else           req1 = 1'b0;
      if (!got) begin
         flag("gnt_timeout");
         return;
      end
      check("rom_en_at_gnt", {31'd0, rom_enable}, {31'd0, ~exp_e});
      if (!exp_e) check("rom_addr_at_gnt", rom_addr, a);
      got = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         if (i == 1) check("rom_en_after", {31'd0, rom_enable}, 32'd0);
         if ((port == 0 && valid0) || (port == 1 && valid1)) begin
            check("latency", 32'(i), exp_e ? 32'd1 : 32'd2);
            got = 1'b1;
            break;
         end
      end
      if (!got) flag("valid_timeout");
   endtask

   initial begin
      int   t0, t1, ngnt;
      bit   got;
      rsp_t r;
      reset = 1'b1;
      req0  = 1'b0;
      req1  = 1'b0;
      addr0 = 32'd0;
      addr1 = 32'd0;
      repeat (2) @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_rom_en", {31'd0, rom_enable}, 32'd0);
      check("rst_rom_addr", rom_addr, 32'd0);
      check("rst_rdata0", rdata0, 32'd0);
      check("rst_rdata1", rdata1, 32'd0);
      check("rst_pulses", {26'd0, gnt0, gnt1, valid0, valid1, err0, err1}, 32'd0);
      reset = 1'b0;

      do_read(0, 32'd0, 32'h03020100, 1'b0);
      do_read(0, 32'd1020, 32'h00000000, 1'b0);
      do_read(1, 32'd1021, 32'h00000000, 1'b1);
      check("rom_addr_hold", rom_addr, 32'd1020);
      do_read(0, 32'hFFFF_FFFC, 32'h00000000, 1'b1);
      do_read(1, 32'd8, 32'h0B0A0908, 1'b0);
      wait_drain();

      // Simultaneous requests straight after reset: port 0 first, port 1 three edges later.
      reset_dut();
      gnt_q.push_back(0);
      gnt_q.push_back(1);
      r = '{0, 32'h07060504, 1'b0}; rsp_q.push_back(r);
      r = '{1, 32'h0B0A0908, 1'b0}; rsp_q.push_back(r);
      @(negedge clk);
      req0 = 1'b1; addr0 = 32'd4;
      req1 = 1'b1; addr1 = 32'd8;
      t0 = 0; t1 = 0;
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (gnt0) begin got = 1'b1; t0 = cyc; req0 = 1'b0; break; end
      end
      if (!got) flag("gnt0_timeout");
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (gnt1) begin got = 1'b1; t1 = cyc; req1 = 1'b0; break; end
      end
      if (!got) flag("gnt1_timeout");
      req0 = 1'b0; req1 = 1'b0;
      check("gnt_spacing", 32'(t1 - t0), 32'd3);
      wait_drain();

      // Both requests held continuously: grants alternate 0,1,0,1.
      reset_dut();
      for (int k = 0; k < 2; k++) begin
         gnt_q.push_back(0);
         gnt_q.push_back(1);
         r = '{0, 32'h03020100, 1'b0}; rsp_q.push_back(r);
         r = '{1, 32'h0F0E0D0C, 1'b0}; rsp_q.push_back(r);
      end
      @(negedge clk);
      req0 = 1'b1; addr0 = 32'd0;
      req1 = 1'b1; addr1 = 32'd12;
      ngnt = 0;
      for (int i = 0; i < 40 && ngnt < 4; i++) begin
         @(negedge clk);
         if (gnt0 || gnt1) ngnt++;
      end
      req0 = 1'b0; req1 = 1'b0;
      check("alt_grants", 32'(ngnt), 32'd4);
      wait_drain();

      // Reset during WAIT aborts the read with no valid pulse.
      gnt_q.push_back(0);
      @(negedge clk);
      req0 = 1'b1; addr0 = 32'd8;
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (gnt0) begin got = 1'b1; break; end
      end
      req0 = 1'b0;
      if (!got) flag("abort_gnt_timeout");
      @(negedge clk);
      check("abort_busy_wait", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_valid", {30'd0, valid0, valid1}, 32'd0);
      reset = 1'b0;
      do_read(0, 32'd4, 32'h07060504, 1'b0);
      wait_drain();

      check("rsp_q_left", 32'(rsp_q.size()), 32'd0);
      check("gnt_q_left", 32'(gnt_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
